muldiv_unit: RTL and testbench

//  Multi-cycle integer multiply/divide unit with architectural HI/LO registers.

---
 rtl/muldiv_unit_if.sv | 45 ++++
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Issue / result bundle between the register-file side and the multiply/divide unit.
// The issuer drives the master side; the unit implements the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hilo_we;
  logic             hilo_sel;
  logic [WIDTH-1:0] hilo_wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start,
    output op,
    output src_a,
    output src_b,
    output hilo_we,
    output hilo_sel,
    output hilo_wdata,
    input  busy,
    input  done,
    input  hi,
    input  lo
  );

  modport slave (
    input  start,
    input  op,
    input  src_a,
    input  src_b,
    input  hilo_we,
    input  hilo_sel,
    input  hilo_wdata,
    output busy,
    output done,
    output hi,
    output lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             is_div;
  logic             div0;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] a_keep;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] quo;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     mul_acc;
  logic [WIDTH-1:0]   mul_quo;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH:0]     div_acc;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH:0]     acc_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // op[0] clear selects the signed variants
  assign sign_a = ~bus.op[0] & bus.src_a[WIDTH-1];
  assign sign_b = ~bus.op[0] & bus.src_b[WIDTH-1];
  assign mag_a  = sign_a ? -bus.src_a : bus.src_a;
  assign mag_b  = sign_b ? -bus.src_b : bus.src_b;

  always_comb begin
    mul_sum = quo[0] ? acc + {1'b0, opnd} : acc;
    mul_acc = {1'b0, mul_sum[WIDTH:1]};
    mul_quo = {mul_sum[0], quo[WIDTH-1:1]};

    div_sh   = {acc[WIDTH-1:0], quo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_acc  = div_sh;
    div_quo  = {quo[WIDTH-2:0], 1'b0};
    if (!div_diff[WIDTH]) begin
      div_acc = div_diff;
      div_quo = {quo[WIDTH-2:0], 1'b1};
    end

    acc_nx = is_div ? div_acc : mul_acc;
    quo_nx = is_div ? div_quo : mul_quo;

    prod   = {mul_acc[WIDTH-1:0], mul_quo};
    prod_s = neg_res ? -prod : prod;
    quot   = neg_res ? -div_quo : div_quo;
    rem    = neg_rem ? -div_acc[WIDTH-1:0]
                     : div_acc[WIDTH-1:0];

    res_hi = '0;
    res_lo = '0;
    unique case (1'b1)
      !is_div: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      is_div && div0: begin
        res_hi = a_keep;
        res_lo = '1;
      end
      is_div && !div0: begin
        res_hi = rem;
        res_lo = quot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      is_div  <= 1'b0;
      div0    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      a_keep  <= '0;
      opnd    <= '0;
      acc     <= '0;
      quo     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.hilo_we) begin
            if (bus.hilo_sel) hi_q <= bus.hilo_wdata;
            else              lo_q <= bus.hilo_wdata;
          end
          if (bus.start) begin
            state   <= BUSY;
            busy_q  <= 1'b1;
            count   <= '0;
            is_div  <= bus.op[1];
            div0    <= bus.op[1] && (bus.src_b == '0);
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            a_keep  <= bus.src_a;
            acc     <= '0;
            // divide shifts the dividend out of quo; multiply shifts the multiplier
            quo     <= bus.op[1] ? mag_a : mag_b;
            opnd    <= bus.op[1] ? mag_b : mag_a;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc   <= acc_nx;
          quo   <= quo_nx;
          count <= count + CW'(1);
          if (count == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            hi_q   <= res_hi;
            lo_q   <= res_lo;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, random model checks and
// hand-written sequences for back-to-back issue, MT writes and abort.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   got_done;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // every cycle step goes through here so no done pulse is missed
  task automatic tick();
    exp_t e;
    @(negedge clk);
    got_done = bus.done;
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("result_hi", bus.hi, e.hi);
        check("result_lo", bus.lo, e.lo);
      end
    end
  endtask

  task automatic issue(input logic [1:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic [W-1:0] ehi,
                       input logic [W-1:0] elo,
                       input bit track);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    if (track) begin
      e.hi = ehi;
      e.lo = elo;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.hilo_we = 1'b0;
    bus.op      = 2'($urandom);
    bus.src_a   = $urandom;
    bus.src_b   = $urandom;
  endtask

  task automatic wait_done(input int k0);
    int lat;
    lat = k0 - 1;
    got_done = 1'b0;
    while (!got_done && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) check("busy_after_start", 32'(bus.busy), 32'd1);
    end
    check("latency", 32'(lat), 32'd33);
    if (got_done) check("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t m;
    longint p;
    longint unsigned u;
    int sa;
    int sb2;
    m.hi = '0;
    m.lo = '0;
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m.hi = p[63:32];
        m.lo = p[31:0];
      end
      2'd1: begin
        u = {32'h0, a} * {32'h0, b};
        m.hi = u[63:32];
        m.lo = u[31:0];
      end
      default: begin
        if (b == '0) begin
          m.hi = a;
          m.lo = '1;
        end else if (o == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m.hi = '0;
          m.lo = 32'h8000_0000;
        end else if (o == 2'd2) begin
          sa = a;
          sb2 = b;
          m.lo = sa / sb2;
          m.hi = sa % sb2;
        end else begin
          m.lo = a / b;
          m.hi = a % b;
        end
      end
    endcase
    return m;
  endfunction

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] h0;
    exp_t m;

    vecs = '{
      '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
      '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
      '{2'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0019},
      '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14},
      '{2'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF},
      '{2'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF},
      '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001},
      '{2'd1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000},
      '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
      '{2'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002},
      '{2'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF}
    };

    bus.start = 1'b0;
    bus.op = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.hilo_we = 1'b0;
    bus.hilo_sel = 1'b0;
    bus.hilo_wdata = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
      wait_done(1);
    end

    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ro[1] ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      m = model(ro, ra, rb);
      issue(ro, ra, rb, m.hi, m.lo, 1'b1);
      wait_done(1);
    end

    // MT writes in IDLE touch only the selected register
    tick();
    h0 = bus.hi;
    bus.hilo_we = 1'b1;
    bus.hilo_sel = 1'b0;
    bus.hilo_wdata = 32'h0000_ABCD;
    @(posedge clk);
    #1 bus.hilo_we = 1'b0;
    tick();
    check("mtlo_lo", bus.lo, 32'h0000_ABCD);
    check("mtlo_hi_held", bus.hi, h0);
    bus.hilo_we = 1'b1;
    bus.hilo_sel = 1'b1;
    bus.hilo_wdata = 32'h5555_0000;
    @(posedge clk);
    #1 bus.hilo_we = 1'b0;
    tick();
    check("mthi_hi", bus.hi, 32'h5555_0000);
    check("mthi_lo_held", bus.lo, 32'h0000_ABCD);

    // start and MT strobe while busy are both ignored
    issue(2'd1, 32'd1000, 32'd1000, 32'd0, 32'h000F_4240, 1'b1);
    for (int k = 1; k <= 4; k++) tick();
    bus.start = 1'b1;
    bus.op = 2'd3;
    bus.src_a = 32'd1;
    bus.src_b = 32'd1;
    bus.hilo_we = 1'b1;
    bus.hilo_sel = 1'b1;
    bus.hilo_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hilo_we = 1'b0;
    tick();
    check("busy_hi_held", bus.hi, 32'h5555_0000);
    wait_done(6);
    for (int k = 0; k < 40; k++) tick();

    // back-to-back: new start in the DONE cycle
    issue(2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    wait_done(1);
    issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done(1);

    // MT write on the accepting edge lands now, result overwrites later
    bus.hilo_we = 1'b1;
    bus.hilo_sel = 1'b0;
    bus.hilo_wdata = 32'h0000_1234;
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    tick();
    check("same_edge_busy", 32'(bus.busy), 32'd1);
    check("same_edge_mtlo", bus.lo, 32'h0000_1234);
    wait_done(2);

    // reset mid-operation aborts without a done pulse
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 9; k++) tick();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    for (int k = 0; k < 40; k++) tick();

    issue(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done(1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
